risc_spm_mem_arbiter: RTL and testbench

- Shares the single-port program/data memory of the RISC_SPM user project between two masters: the RISC_SPM core's memory port and the Caravel Wishbone slave port.
- The management SoC uses the Wishbone port to load programs and read back results.
- Arbitration is fixed-priority to the core, with a starvation guard for the host.
- A host-driven load mode holds the core off the memory entirely.

---
 rtl/risc_spm_mem_arbiter_if.sv | 51 +++++
 rtl/risc_spm_mem_arbiter.sv | 119 +++++++++++
 tb/tb_risc_spm_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_spm_mem_arbiter_if.sv
// Bus bundle between the RISC_SPM memory arbiter and its neighbours.
// Groups the three sides of the arbiter:
//   wbs_*  : Caravel Wishbone slave port (host side)
//   core_* : RISC_SPM core memory port
//   mem_*  : single-port synchronous program/data memory
// Modports:
//   slave  : the arbiter's view (takes requests, drives acks and memory)
//   master : the environment's view (host, core and memory together)
interface risc_spm_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic              wbs_we_i;
    logic [ADDR_W-1:0] wbs_adr_i;
    logic [DATA_W-1:0] wbs_dat_i;
    logic              wbs_ack_o;
    logic [DATA_W-1:0] wbs_dat_o;

    logic              core_req_i;
    logic              core_we_i;
    logic [ADDR_W-1:0] core_addr_i;
    logic [DATA_W-1:0] core_wdata_i;
    logic              core_ack_o;
    logic [DATA_W-1:0] core_rdata_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
        output core_ack_o, core_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        output core_req_i, core_we_i, core_addr_i, core_wdata_i,
        input  core_ack_o, core_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/risc_spm_mem_arbiter.sv
// Memory arbiter for the RISC_SPM user project.
// Shares one single-port memory between the core and the Wishbone host.
// The core has fixed priority; a starvation counter lets the host in after
// STARVE_MAX consecutive core grants. load_mode_i locks the core out so the
// host can load programs. Every access takes two cycles: an issue cycle in
// IDLE that drives the memory, then an ack cycle that returns read data.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   load_mode_i  1 = core never granted
//   bus          slave modport of risc_spm_mem_arbiter_if (wbs/core/mem)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | issue cycle: pick a winner, drive memory combinationally
// CORE_DONE  | memory read data valid; ack the core for one cycle
// HOST_DONE  | memory read data valid; ack the host for one cycle
module risc_spm_mem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_mode_i,
    risc_spm_mem_arbiter_if.slave        bus
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_CORE_DONE = 2'd1;
    localparam logic [1:0] S_HOST_DONE = 2'd2;

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_nxt;
    logic             host_req;
    logic             core_ok;
    logic             starve_ok;

    // wbs_ack_o is high exactly in HOST_DONE, so masking with the state
    // avoids feeding the ack output back into its own decode block.
    assign host_req = bus.wbs_cyc_i & bus.wbs_stb_i & (state != S_HOST_DONE);
    assign core_ok  = bus.core_req_i & ~load_mode_i;

    // With STARVE_MAX = 0 the core never wins a tie against the host.
    generate
        if (STARVE_MAX == 0) begin : g_no_starve
            assign starve_ok = 1'b0;
        end else begin : g_starve
            assign starve_ok = (starve_cnt < CNT_W'(STARVE_MAX));
        end
    endgenerate

    // Outputs are gated by rst_n so that asserting reset clears them at once,
    // including the combinational issue-cycle drive of the memory.
    always_comb begin
        state_nxt        = state;
        starve_cnt_nxt   = starve_cnt;
        bus.mem_en_o     = 1'b0;
        bus.mem_we_o     = 1'b0;
        bus.mem_addr_o   = {ADDR_W{1'b0}};
        bus.mem_wdata_o  = {DATA_W{1'b0}};
        bus.wbs_ack_o    = 1'b0;
        bus.wbs_dat_o    = {DATA_W{1'b0}};
        bus.core_ack_o   = 1'b0;
        bus.core_rdata_o = {DATA_W{1'b0}};
        if (rst_n) begin
            case (state)
                S_IDLE: begin
                    if (core_ok && (!host_req || starve_ok)) begin
                        bus.mem_en_o    = 1'b1;
                        bus.mem_we_o    = bus.core_we_i;
                        bus.mem_addr_o  = bus.core_addr_i;
                        bus.mem_wdata_o = bus.core_wdata_i;
                        state_nxt       = S_CORE_DONE;
                        // starve_ok guarantees headroom, so no wrap here
                        starve_cnt_nxt  = host_req ? starve_cnt + 1'b1 : '0;
                    end else if (host_req) begin
                        bus.mem_en_o    = 1'b1;
                        bus.mem_we_o    = bus.wbs_we_i;
                        bus.mem_addr_o  = bus.wbs_adr_i;
                        bus.mem_wdata_o = bus.wbs_dat_i;
                        state_nxt       = S_HOST_DONE;
                        starve_cnt_nxt  = '0;
                    end else begin
                        starve_cnt_nxt  = '0;
                    end
                end
                S_CORE_DONE: begin
                    bus.core_ack_o   = 1'b1;
                    bus.core_rdata_o = bus.mem_rdata_i;
                    state_nxt        = S_IDLE;
                end
                S_HOST_DONE: begin
                    bus.wbs_ack_o = 1'b1;
                    bus.wbs_dat_o = bus.mem_rdata_i;
                    state_nxt     = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_risc_spm_mem_arbiter.sv
// Self-checking bench for risc_spm_mem_arbiter.
// Two instances share clk/rst_n: dut_a with STARVE_MAX = 4 and dut_b with
// STARVE_MAX = 0. Each has a behavioural synchronous memory. Directed steps
// cover the listed scenarios; a randomized phase compares every ack against
// a shadow memory and checks the host-fairness and load-mode rules.
module tb_risc_spm_mem_arbiter;

    localparam int SM_A = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic lm_a;
    logic lm_b;

    always #5 clk = ~clk;

    risc_spm_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) ia ();
    risc_spm_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) ib ();

    risc_spm_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(SM_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .load_mode_i(lm_a), .bus(ia)
    );
    risc_spm_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .load_mode_i(lm_b), .bus(ib)
    );

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    always @(posedge clk) begin
        if (ia.mem_en_o) begin
            if (ia.mem_we_o) mem_a[ia.mem_addr_o] <= ia.mem_wdata_o;
            ia.mem_rdata_i <= mem_a[ia.mem_addr_o];
        end
        if (ib.mem_en_o) begin
            if (ib.mem_we_o) mem_b[ib.mem_addr_o] <= ib.mem_wdata_o;
            ib.mem_rdata_i <= mem_b[ib.mem_addr_o];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic host_xfer(input logic we, input logic [7:0] a, input logic [7:0] d,
                             output logic [7:0] rd, output int lat);
        ia.wbs_cyc_i = 1'b1; ia.wbs_stb_i = 1'b1; ia.wbs_we_i = we;
        ia.wbs_adr_i = a;    ia.wbs_dat_i = d;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ia.wbs_ack_o && lat < 50);
        rd = ia.wbs_dat_o;
        ia.wbs_cyc_i = 1'b0; ia.wbs_stb_i = 1'b0; ia.wbs_we_i = 1'b0;
    endtask

    task automatic core_xfer(input logic we, input logic [7:0] a, input logic [7:0] d,
                             output logic [7:0] rd, output int lat);
        ia.core_req_i = 1'b1; ia.core_we_i = we;
        ia.core_addr_i = a;   ia.core_wdata_i = d;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ia.core_ack_o && lat < 50);
        rd = ia.core_rdata_o;
        ia.core_req_i = 1'b0; ia.core_we_i = 1'b0;
    endtask

    // random-phase model state
    logic [7:0] shadow [16];
    bit         known  [16];
    bit         h_pend, c_pend, h_pend_prev, lm_prev;
    logic       h_we, c_we;
    logic [7:0] h_adr, c_adr, h_dat, c_dat;
    int         streak, h_wait;

    task automatic rnd_cycle(input bit allow_new);
        tick();
        chk("rnd_one_ack", {31'd0, ia.core_ack_o & ia.wbs_ack_o}, 0);
        if (ia.core_ack_o) begin
            chk("rnd_core_pend", {31'd0, c_pend}, 1);
            chk("rnd_lm_block", {31'd0, lm_prev}, 0);
            if (c_we) begin
                shadow[c_adr[3:0]] = c_dat; known[c_adr[3:0]] = 1'b1;
            end else if (known[c_adr[3:0]]) begin
                chk("rnd_core_rd", ia.core_rdata_o, shadow[c_adr[3:0]]);
            end
            streak = h_pend_prev ? streak + 1 : 0;
            chk("rnd_starve", {31'd0, streak <= SM_A}, 1);
            c_pend = 1'b0;
        end
        if (ia.wbs_ack_o) begin
            chk("rnd_host_pend", {31'd0, h_pend}, 1);
            chk("rnd_host_wait", {31'd0, h_wait <= 2 * SM_A + 2}, 1);
            if (h_we) begin
                shadow[h_adr[3:0]] = h_dat; known[h_adr[3:0]] = 1'b1;
            end else if (known[h_adr[3:0]]) begin
                chk("rnd_host_rd", ia.wbs_dat_o, shadow[h_adr[3:0]]);
            end
            streak = 0;
            h_pend = 1'b0;
        end
        if (allow_new && !h_pend && ($urandom % 3 == 0)) begin
            h_pend = 1'b1; h_wait = 0;
            h_we = 1'($urandom % 2); h_adr = 8'($urandom % 16); h_dat = 8'($urandom);
        end
        if (allow_new && !c_pend && ($urandom % 2 == 0)) begin
            c_pend = 1'b1;
            c_we = 1'($urandom % 2); c_adr = 8'($urandom % 16); c_dat = 8'($urandom);
        end
        if (allow_new && ($urandom % 16 == 0)) lm_a = ~lm_a;
        if (!allow_new) lm_a = 1'b0;
        ia.wbs_cyc_i = h_pend; ia.wbs_stb_i = h_pend; ia.wbs_we_i = h_pend & h_we;
        ia.wbs_adr_i = h_adr;  ia.wbs_dat_i = h_dat;
        ia.core_req_i = c_pend; ia.core_we_i = c_pend & c_we;
        ia.core_addr_i = c_adr; ia.core_wdata_i = c_dat;
        if (h_pend) h_wait++;
        h_pend_prev = h_pend;
        lm_prev     = lm_a;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int         lat;
        byte        grants [$];
        int         h_cycles [$];
        int         n_h, n_c, bad;

        rst_n = 1'b0; lm_a = 1'b0; lm_b = 1'b0;
        ia.wbs_cyc_i = 0; ia.wbs_stb_i = 0; ia.wbs_we_i = 0; ia.wbs_adr_i = 0; ia.wbs_dat_i = 0;
        ia.core_req_i = 0; ia.core_we_i = 0; ia.core_addr_i = 0; ia.core_wdata_i = 0;
        ib.wbs_cyc_i = 0; ib.wbs_stb_i = 0; ib.wbs_we_i = 0; ib.wbs_adr_i = 0; ib.wbs_dat_i = 0;
        ib.core_req_i = 0; ib.core_we_i = 0; ib.core_addr_i = 0; ib.core_wdata_i = 0;
        repeat (3) tick();

        // reset values
        chk("rst_mem_en", {31'd0, ia.mem_en_o}, 0);
        chk("rst_mem_we", {31'd0, ia.mem_we_o}, 0);
        chk("rst_mem_addr", ia.mem_addr_o, 0);
        chk("rst_wbs_ack", {31'd0, ia.wbs_ack_o}, 0);
        chk("rst_core_ack", {31'd0, ia.core_ack_o}, 0);
        chk("rst_wbs_dat", ia.wbs_dat_o, 0);
        chk("rst_core_rdata", ia.core_rdata_o, 0);
        rst_n = 1'b1;
        tick();

        // host write 0xA5 -> 0x10, cycle-accurate
        ia.wbs_cyc_i = 1; ia.wbs_stb_i = 1; ia.wbs_we_i = 1; ia.wbs_adr_i = 8'h10; ia.wbs_dat_i = 8'hA5;
        #1;
        chk("hw_mem_en", {31'd0, ia.mem_en_o}, 1);
        chk("hw_mem_we", {31'd0, ia.mem_we_o}, 1);
        chk("hw_mem_addr", ia.mem_addr_o, 8'h10);
        chk("hw_mem_wdata", ia.mem_wdata_o, 8'hA5);
        chk("hw_no_ack_c0", {31'd0, ia.wbs_ack_o}, 0);
        tick();
        chk("hw_ack_c1", {31'd0, ia.wbs_ack_o}, 1);
        ia.wbs_cyc_i = 0; ia.wbs_stb_i = 0; ia.wbs_we_i = 0;
        #1;
        chk("hw_mem_idle", {31'd0, ia.mem_en_o}, 0);
        tick();
        chk("hw_ack_once", {31'd0, ia.wbs_ack_o}, 0);

        // single-master accesses and back-to-back re-requests
        host_xfer(0, 8'h10, 8'h00, rd, lat);
        chk("hr10_lat", lat, 1);
        chk("hr10_data", rd, 8'hA5);
        core_xfer(0, 8'h10, 8'h00, rd, lat);
        chk("cr10_lat", lat, 2);
        chk("cr10_data", rd, 8'hA5);
        core_xfer(1, 8'h11, 8'h3C, rd, lat);
        chk("cw11_lat", lat, 2);
        host_xfer(0, 8'h11, 8'h00, rd, lat);
        chk("hr11_lat", lat, 2);
        chk("hr11_data", rd, 8'h3C);
        tick();

        // both masters continuous, STARVE_MAX = 4
        ia.wbs_cyc_i = 1; ia.wbs_stb_i = 1; ia.wbs_adr_i = 8'h10;
        ia.core_req_i = 1; ia.core_addr_i = 8'h11;
        for (int i = 1; i <= 39; i++) begin
            tick();
            if (ia.core_ack_o) grants.push_back("C");
            if (ia.wbs_ack_o) begin
                grants.push_back("H");
                h_cycles.push_back(i);
            end
        end
        ia.wbs_cyc_i = 0; ia.wbs_stb_i = 0; ia.core_req_i = 0;
        chk("cont_grants", grants.size(), 20);
        bad = 0;
        for (int k = 0; k < grants.size(); k++)
            if (grants[k] != ((k % (SM_A + 1) == SM_A) ? 8'("H") : 8'("C"))) bad++;
        chk("cont_pattern_bad", bad, 0);
        chk("cont_host_acks", h_cycles.size(), 4);
        bad = 0;
        for (int k = 1; k < h_cycles.size(); k++)
            if (h_cycles[k] - h_cycles[k-1] != 10) bad++;
        chk("cont_host_spacing_bad", bad, 0);
        tick();

        // STARVE_MAX = 0: host wins every tie
        ib.wbs_cyc_i = 1; ib.wbs_stb_i = 1; ib.wbs_adr_i = 8'h05;
        ib.core_req_i = 1; ib.core_addr_i = 8'h06;
        n_h = 0; n_c = 0;
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (ib.wbs_ack_o) n_h++;
            if (ib.core_ack_o) n_c++;
        end
        ib.wbs_cyc_i = 0; ib.wbs_stb_i = 0;
        chk("sm0_host_acks", n_h, 10);
        chk("sm0_core_acks", n_c, 0);
        tick();
        #1;
        chk("sm0_core_issue", {31'd0, ib.mem_en_o}, 1);
        tick();
        chk("sm0_core_ack", {31'd0, ib.core_ack_o}, 1);
        ib.core_req_i = 0;
        tick();

        // load mode: core locked out, host still served
        lm_a = 1'b1;
        ia.core_req_i = 1; ia.core_we_i = 0; ia.core_addr_i = 8'h10;
        ia.wbs_cyc_i = 1; ia.wbs_stb_i = 1; ia.wbs_we_i = 0; ia.wbs_adr_i = 8'h11;
        n_h = 0; n_c = 0; bad = 0;
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (ia.core_ack_o) n_c++;
            if (ia.wbs_ack_o) begin
                n_h++;
                if (ia.wbs_dat_o !== 8'h3C) bad++;
            end
        end
        ia.wbs_cyc_i = 0; ia.wbs_stb_i = 0;
        lm_a = 1'b0;
        chk("lm_core_acks", n_c, 0);
        chk("lm_host_acks", n_h, 10);
        chk("lm_host_data_bad", bad, 0);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ia.core_ack_o && lat < 10);
        chk("lm_release_ack", {31'd0, lat <= 2}, 1);
        chk("lm_release_data", ia.core_rdata_o, 8'hA5);
        ia.core_req_i = 0;
        tick();

        // reset during CORE_DONE
        ia.core_req_i = 1; ia.core_we_i = 0; ia.core_addr_i = 8'h10;
        tick();
        chk("rm_ack_before", {31'd0, ia.core_ack_o}, 1);
        rst_n = 1'b0;
        #1;
        chk("rm_ack_dropped", {31'd0, ia.core_ack_o}, 0);
        chk("rm_rdata_cleared", ia.core_rdata_o, 0);
        chk("rm_mem_en", {31'd0, ia.mem_en_o}, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rm_reissue", {31'd0, ia.mem_en_o}, 1);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ia.core_ack_o && lat < 10);
        chk("rm_retry_lat", lat, 1);
        chk("rm_retry_data", ia.core_rdata_o, 8'hA5);
        ia.core_req_i = 0;
        tick();

        // randomized traffic against the shadow-memory model
        for (int i = 0; i < 16; i++) known[i] = 1'b0;
        h_pend = 0; c_pend = 0; h_pend_prev = 0; lm_prev = 0; streak = 0; h_wait = 0;
        h_we = 0; c_we = 0; h_adr = 0; c_adr = 0; h_dat = 0; c_dat = 0;
        for (int i = 0; i < 600; i++) rnd_cycle(1'b1);
        for (int i = 0; i < 40 && (h_pend || c_pend); i++) rnd_cycle(1'b0);
        chk("rnd_drain", {30'd0, h_pend, c_pend}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
